// File: rtl/sig_debouncer.sv
// sig_debouncer: synchronises one asynchronous level input and commits a new
// level only after it has been seen for STABLE_CYCLES consecutive samples.
// Transitions that are abandoned before qualifying are counted in a
// saturating diagnostic counter.
module sig_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig_in,
    input  logic                glitch_clr,
    output logic                sig_out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sig_sync;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   r_sig_out;
    logic                   w_sig_out_next;
    logic                   w_glitch;
    logic [GLITCH_W-1:0]    r_glitch_cnt;

    // Synchroniser chain: s[0] captures the raw pin, the last stage feeds the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign w_sig_sync = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc  = r_cnt + CNT_ONE;

    // State register together with the qualification counter and the level flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= STABLE_LO;
            r_cnt     <= CNT_ZERO;
            r_sig_out <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_sig_out <= w_sig_out_next;
        end
    end

    // Next-state logic: qualify a candidate level, commit it or abort as a glitch.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_sig_out_next = r_sig_out;
        w_glitch       = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_sig_sync) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_next   = STABLE_HI;
                        w_sig_out_next = 1'b1;
                        w_cnt_next     = CNT_ZERO;
                    end else begin
                        w_state_next = WAIT_HI;
                        w_cnt_next   = CNT_ONE;
                    end
                end
            end
            WAIT_HI: begin
                if (w_sig_sync) begin
                    if (w_cnt_inc == CNT_LAST) begin
                        w_state_next   = STABLE_HI;
                        w_sig_out_next = 1'b1;
                        w_cnt_next     = CNT_ZERO;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end else begin
                    w_state_next = STABLE_LO;
                    w_cnt_next   = CNT_ZERO;
                    w_glitch     = 1'b1;
                end
            end
            STABLE_HI: begin
                if (!w_sig_sync) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_next   = STABLE_LO;
                        w_sig_out_next = 1'b0;
                        w_cnt_next     = CNT_ZERO;
                    end else begin
                        w_state_next = WAIT_LO;
                        w_cnt_next   = CNT_ONE;
                    end
                end
            end
            WAIT_LO: begin
                if (!w_sig_sync) begin
                    if (w_cnt_inc == CNT_LAST) begin
                        w_state_next   = STABLE_LO;
                        w_sig_out_next = 1'b0;
                        w_cnt_next     = CNT_ZERO;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end else begin
                    w_state_next = STABLE_HI;
                    w_cnt_next   = CNT_ZERO;
                    w_glitch     = 1'b1;
                end
            end
            default: begin
                w_state_next   = STABLE_LO;
                w_cnt_next     = CNT_ZERO;
                w_sig_out_next = 1'b0;
            end
        endcase
    end

    // Output decode: busy comes from the state register alone.
    always_comb begin
        busy    = (r_state == WAIT_HI) || (r_state == WAIT_LO);
        sig_out = r_sig_out;
    end

    // Saturating glitch counter; a clear in the same cycle as an abort wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_glitch_cnt <= '0;
        end else if (glitch_clr) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != GLITCH_MAX)) begin
            r_glitch_cnt <= r_glitch_cnt + 1'b1;
        end
    end

    assign glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_sig_debouncer.sv
// tb_sig_debouncer: directed checks of three debouncer configurations
// (default-style qualification, narrow glitch counter, single-cycle qualify).
module tb_sig_debouncer;

    logic clk;

    // A: SYNC 2, STABLE 4, GLITCH_W 8
    logic       a_rst, a_in, a_clr, a_out, a_busy;
    logic [7:0] a_gc;
    // B: SYNC 2, STABLE 4, GLITCH_W 2
    logic       b_rst, b_in, b_clr, b_out, b_busy;
    logic [1:0] b_gc;
    // C: SYNC 2, STABLE 1, GLITCH_W 8
    logic       c_rst, c_in, c_clr, c_out, c_busy;
    logic [7:0] c_gc;

    int n_cmp  = 0;
    int n_fail = 0;

    sig_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_W(8)) u_a (
        .clk(clk), .rst(a_rst), .sig_in(a_in), .glitch_clr(a_clr),
        .sig_out(a_out), .busy(a_busy), .glitch_cnt(a_gc)
    );

    sig_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_W(2)) u_b (
        .clk(clk), .rst(b_rst), .sig_in(b_in), .glitch_clr(b_clr),
        .sig_out(b_out), .busy(b_busy), .glitch_cnt(b_gc)
    );

    sig_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .GLITCH_W(8)) u_c (
        .clk(clk), .rst(c_rst), .sig_in(c_in), .glitch_clr(c_clr),
        .sig_out(c_out), .busy(c_busy), .glitch_cnt(c_gc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin : stim
        int  exp_sat [5];
        logic c_new;
        exp_sat = '{1, 2, 3, 3, 3};

        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_in  = 1'b1; b_in  = 1'b0; c_in  = 1'b0;
        a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;

        // Reset held with input high
        ticks(3);
        chk("rst_out", a_out, 8'd0);
        chk("rst_busy", a_busy, 8'd0);
        chk("rst_gc", a_gc, 8'd0);

        // Release: held-high input qualifies as a normal rise
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        ticks(2);
        chk("rel_busy_e1", a_busy, 8'd0);
        tick();
        chk("rel_busy_e2", a_busy, 8'd1);
        chk("rel_out_e2", a_out, 8'd0);
        ticks(2);
        chk("rel_out_e4", a_out, 8'd0);
        tick();
        chk("rel_out_e5", a_out, 8'd1);
        chk("rel_busy_e5", a_busy, 8'd0);
        chk("rel_gc_e5", a_gc, 8'd0);

        // Clean fall
        a_in = 1'b0;
        ticks(3);
        chk("fall_busy_e2", a_busy, 8'd1);
        chk("fall_out_e2", a_out, 8'd1);
        ticks(2);
        chk("fall_out_e4", a_out, 8'd1);
        tick();
        chk("fall_out_e5", a_out, 8'd0);
        chk("fall_busy_e5", a_busy, 8'd0);

        // 3-cycle pulse: aborted, one glitch
        a_in = 1'b1;
        ticks(3);
        a_in = 1'b0;
        ticks(2);
        chk("g3_busy_e4", a_busy, 8'd1);
        chk("g3_out_e4", a_out, 8'd0);
        tick();
        chk("g3_gc_e5", a_gc, 8'd1);
        chk("g3_busy_e5", a_busy, 8'd0);
        chk("g3_out_e5", a_out, 8'd0);
        ticks(3);
        chk("g3_out_late", a_out, 8'd0);

        // 4-cycle pulse: commits, then falls back
        a_in = 1'b1;
        ticks(4);
        a_in = 1'b0;
        tick();
        chk("p4_out_e4", a_out, 8'd0);
        tick();
        chk("p4_out_e5", a_out, 8'd1);
        chk("p4_busy_e5", a_busy, 8'd0);
        ticks(3);
        chk("p4_out_e8", a_out, 8'd1);
        chk("p4_busy_e8", a_busy, 8'd1);
        tick();
        chk("p4_out_e9", a_out, 8'd0);
        chk("p4_gc_e9", a_gc, 8'd1);

        // Synchronous clear
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("clr_gc", a_gc, 8'd0);

        // Reset while in WAIT_HI with cnt=2
        a_in = 1'b1;
        ticks(4);
        chk("mid_busy_pre", a_busy, 8'd1);
        #2;
        a_rst = 1'b0;
        #1;
        chk("mid_busy_async", a_busy, 8'd0);
        chk("mid_out_async", a_out, 8'd0);
        chk("mid_gc_async", a_gc, 8'd0);
        ticks(2);
        a_rst = 1'b1;
        ticks(5);
        chk("mid_out_e4", a_out, 8'd0);
        chk("mid_gc_e4", a_gc, 8'd0);
        tick();
        chk("mid_out_e5", a_out, 8'd1);

        // Saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            b_in = 1'b1;
            tick();
            b_in = 1'b0;
            ticks(3);
            chk($sformatf("sat_gc_%0d", i), 8'(b_gc), 8'(exp_sat[i]));
            chk($sformatf("sat_busy_%0d", i), b_busy, 8'd0);
            tick();
        end
        // Clear coincident with a sixth abort
        b_in = 1'b1;
        tick();
        b_in = 1'b0;
        ticks(2);
        chk("sat_gc_pre_clr", 8'(b_gc), 8'd3);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("sat_gc_clr_abort", 8'(b_gc), 8'd0);
        chk("sat_out", b_out, 8'd0);

        // Single-cycle qualification: 3-edge follow, never busy
        for (int k = 0; k < 4; k++) begin
            c_in  = ~c_in;
            c_new = c_in;
            ticks(2);
            chk($sformatf("sc1_out_e1_%0d", k), c_out, 8'(!c_new));
            chk($sformatf("sc1_busy_e1_%0d", k), c_busy, 8'd0);
            tick();
            chk($sformatf("sc1_out_e2_%0d", k), c_out, 8'(c_new));
            chk($sformatf("sc1_busy_e2_%0d", k), c_busy, 8'd0);
            chk($sformatf("sc1_gc_%0d", k), c_gc, 8'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sig_debouncer.md
# sig_debouncer

Synchronises and debounces one asynchronous level input (push-button, strap, external status pin) into a clean single-bit level in the `clk` domain. The block sits directly upstream of the rising/falling edge detectors: its `sig_out` drives their `sig` input, so that each physical transition yields exactly one edge pulse. It also keeps a saturating count of rejected glitches for diagnostics.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops on `sig_in`; legal values ≥ 2.
- `STABLE_CYCLES`, default 16: number of consecutive synchronised samples at the new level required to commit a transition; legal values ≥ 1.
- `GLITCH_W`, default 8: width of `glitch_cnt`.
- Counter width is derived from the parameters: `$clog2(STABLE_CYCLES+1)`.
- `clk`, input, 1: single clock; all state updates on posedge.
- `rst`, input, 1: reset; asynchronous assert, active-low.
- `sig_in`, input, 1: raw asynchronous level.
- `glitch_clr`, input, 1: synchronous clear of `glitch_cnt`.
- `sig_out`, output, 1: debounced level, registered.
- `busy`, output, 1: high while a candidate transition is being qualified.
- `glitch_cnt`, output, GLITCH_W: saturating count of aborted transitions.

## Operation
- **Synchroniser.** Chain `s[0..SYNC_STAGES-1]`. `s[0]` samples `sig_in` each edge. `sig_sync = s[SYNC_STAGES-1]`. Only `sig_sync` is used by logic beyond the chain.
- **FSM states:** `STABLE_LO`, `WAIT_HI`, `STABLE_HI`, `WAIT_LO`. `cnt` holds the number of qualifying samples seen so far.
- **`STABLE_LO`** (`sig_out`=0):
  - If `sig_sync`=0, stay.
  - If `sig_sync`=1 and `STABLE_CYCLES`=1, go to `STABLE_HI` and set `sig_out`<=1.
  - If `sig_sync`=1 otherwise, go to `WAIT_HI` with `cnt`<=1.
- **`WAIT_HI`** (`sig_out`=0):
  - If `sig_sync`=1 and `cnt+1`==`STABLE_CYCLES`, go to `STABLE_HI`, set `sig_out`<=1, `cnt`<=0.
  - If `sig_sync`=1 otherwise, `cnt`<=`cnt`+1.
  - If `sig_sync`=0, this is a glitch: go to `STABLE_LO`, `cnt`<=0, increment `glitch_cnt`.
- **`STABLE_HI`** and **`WAIT_LO`** are mirror images of the above with polarities swapped. `sig_out` stays 1 until the commit to `STABLE_LO`.
- **Outputs.**
  - `busy` = (state==`WAIT_HI`) or (state==`WAIT_LO`), decoded from the state register only. There is no combinational path from `sig_in`.
  - `sig_out` is a dedicated flop. It changes only on a commit transition.
- **`glitch_cnt`.**
  - Increments by 1 on each glitch abort and saturates at all-ones (no wrap).
  - `glitch_clr`=1 sets it to 0 on the next edge. If `glitch_clr` and a glitch abort occur in the same cycle, the clear wins and the result is 0.
- **Reset.** Asynchronous, active-low `rst` forces every flop low regardless of state, including mid-qualification:
  - all `s[]` = 0, state = `STABLE_LO`, `cnt` = 0;
  - `sig_out` = 0, `busy` = 0, `glitch_cnt` = 0.
  - After deassertion, an input already held high is qualified as a normal low→high transition.

## Timing
- **Transition latency.** Suppose `sig_in` changes before edge E0 and stays stable. `sig_sync` changes after edge E(SYNC_STAGES-1). `sig_out` changes after edge E(SYNC_STAGES+STABLE_CYCLES-1), i.e. SYNC_STAGES+STABLE_CYCLES edges including the capture edge. With the defaults this is 18 edges.
- **`busy` window.**
  - Rises after edge E(SYNC_STAGES) when `STABLE_CYCLES` ≥ 2.
  - Falls on the same edge that `sig_out` changes.
  - Stays 0 throughout when `STABLE_CYCLES`=1.
- **Glitch width.**
  - A pulse seen at `sig_sync` for fewer than `STABLE_CYCLES` cycles never reaches `sig_out` and adds exactly 1 to `glitch_cnt`.
  - A pulse seen for exactly `STABLE_CYCLES` cycles always commits.
- **Pulse rate.** `sig_out` toggles at most once per `STABLE_CYCLES` cycles. Downstream edge detectors therefore never see back-to-back edges closer than that.
- **Clear timing.** `glitch_clr` takes effect one edge after it is sampled high.
- **Reset timing.** Outputs go low asynchronously on `rst` falling. The first functional update is on the first posedge after `rst` rises.

## Test plan
All scenarios use `SYNC_STAGES`=2 and `STABLE_CYCLES`=4 unless noted otherwise.
- **Reset values.** Hold `rst`=0 with `sig_in`=1 → `sig_out`=0, `busy`=0, `glitch_cnt`=0. Release `rst` → `sig_out`=1 after the 6th posedge following release, `glitch_cnt`=0.
- **Clean transitions.** Step `sig_in` 0→1 before E0 → `busy`=1 after E2, `sig_out`=1 and `busy`=0 after E5. Step 1→0 → `sig_out`=0 exactly 6 edges later.
- **Glitch and boundary.** 3-cycle high pulse on `sig_in` → `sig_out` stays 0, `glitch_cnt`=1, `busy` returns to 0. 4-cycle high pulse → `sig_out` rises and later falls, `glitch_cnt` unchanged.
- **Saturation and clear.** With `GLITCH_W`=2, apply 5 short glitches → `glitch_cnt` sequence 1, 2, 3, 3, 3. Assert `glitch_clr` on the same cycle as a 6th abort → `glitch_cnt`=0.
- **Reset mid-operation.** Assert `rst` while in `WAIT_HI` with `cnt`=2 → `busy` and `sig_out` drop immediately, no glitch counted. After release, a held-high input takes a full 6 edges to commit.
- **Single-cycle qualification.** With `STABLE_CYCLES`=1, toggle `sig_in` every 3 cycles → `sig_out` follows with a 3-edge delay, `busy` stays 0, `glitch_cnt` stays 0.
